// File: rtl/conv1_filter_engine.sv
// conv1 filter engine: fetches w0/w1/b per filter and streams one saturated MAC result per filter.
// Optional build macro CONV1_FILTER_ENGINE_RELU_EN clamps negative results to zero.
module conv1_filter_engine #(
    parameter int NUM_FILTERS = 20,
    parameter int FRAC_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x0,
    input  logic [15:0] in_x1,
    output logic        mem_start,
    output logic [4:0]  mem_filter,
    input  logic [15:0] mem_w0,
    input  logic [15:0] mem_w1,
    input  logic [31:0] mem_b,
    input  logic        mem_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [4:0]  out_filter,
    output logic        out_last,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_MAC   = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [4:0] LAST_IDX = 5'(NUM_FILTERS - 1);

    logic [1:0]         state_q, state_d;
    logic [4:0]         idx_q, idx_d;
    logic signed [15:0] x0_q, x0_d, x1_q, x1_d;
    logic signed [15:0] w0_q, w0_d, w1_q, w1_d;
    logic signed [31:0] b_q, b_d;
    logic signed [15:0] out_data_q, out_data_d;

    logic signed [31:0] prod0, prod1;
    logic signed [33:0] acc, res;
    logic signed [15:0] sat_res;

    // Products are widened before summing so the bias add cannot overflow.
    always_comb begin
        prod0   = 32'(x0_q) * 32'(w0_q);
        prod1   = 32'(x1_q) * 32'(w1_q);
        acc     = 34'(prod0) + 34'(prod1) + 34'(b_q);
        res     = acc >>> FRAC_BITS;
        sat_res = res[15:0];
        if (res > 34'sd32767) begin
            sat_res = 16'sh7fff;
        end else if (res < -34'sd32768) begin
            sat_res = 16'sh8000;
        end
`ifdef CONV1_FILTER_ENGINE_RELU_EN
        if (sat_res[15]) begin
            sat_res = '0;
        end
`endif
    end

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        b_d        = b_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x0_d    = in_x0;
                    x1_d    = in_x1;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_done) begin
                    w0_d    = mem_w0;
                    w1_d    = mem_w1;
                    b_d     = mem_b;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                out_data_d = sat_res;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            w0_q       <= '0;
            w1_q       <= '0;
            b_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            b_q        <= b_d;
            out_data_q <= out_data_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    assign in_ready   = rst_n && (state_q == S_IDLE);
    assign mem_start  = (state_q == S_FETCH);
    assign mem_filter = idx_q;
    assign out_valid  = (state_q == S_OUT);
    assign out_data   = out_data_q;
    assign out_filter = idx_q;
    assign out_last   = (state_q == S_OUT) && (idx_q == LAST_IDX);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv1_filter_engine.sv
// Randomized bench for conv1_filter_engine: latency-randomized weight memory and an arithmetic reference model.
module tb_conv1_filter_engine;

    localparam int NF = 20;
    localparam int FB = 8;
`ifdef CONV1_FILTER_ENGINE_RELU_EN
    localparam longint EXP_F19    = 0;
    localparam longint EXP_SATNEG = 0;
`else
    localparam longint EXP_F19    = -7342;
    localparam longint EXP_SATNEG = -32768;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x0 = '0;
    logic [15:0] in_x1 = '0;
    logic        mem_start;
    logic [4:0]  mem_filter;
    logic [15:0] mem_w0;
    logic [15:0] mem_w1;
    logic [31:0] mem_b;
    logic        mem_done;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [4:0]  out_filter;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    conv1_filter_engine #(.NUM_FILTERS(NF), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x0(in_x0), .in_x1(in_x1),
        .mem_start(mem_start), .mem_filter(mem_filter),
        .mem_w0(mem_w0), .mem_w1(mem_w1), .mem_b(mem_b), .mem_done(mem_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_filter(out_filter), .out_last(out_last), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    logic signed [15:0] wm0 [32];
    logic signed [15:0] wm1 [32];
    logic signed [31:0] bm  [32];
    longint             got_d [NF];

    // Weight memory model: done after mem_delay cycles of mem_start, random noise on mem_done otherwise.
    int   mem_delay = 0;
    int   wait_cnt;
    logic stray_done = 1'b0;
    int   n_acc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (mem_start && !mem_done) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(negedge clk) stray_done <= 1'($urandom_range(0, 1));
    always @(posedge clk) if (rst_n && in_valid && in_ready) n_acc <= n_acc + 1;

    assign mem_done = mem_start ? (wait_cnt >= mem_delay) : stray_done;
    assign mem_w0   = wm0[mem_filter];
    assign mem_w1   = wm1[mem_filter];
    assign mem_b    = bm[mem_filter];

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint model(input longint x0, input longint x1, input int f);
        longint acc, r;
        acc = x0 * longint'(wm0[f]) + x1 * longint'(wm1[f]) + longint'(bm[f]);
        r   = acc >>> FB;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef CONV1_FILTER_ENGINE_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic send_pair(input logic signed [15:0] x0, input logic signed [15:0] x1);
        int cnt = 0;
        in_x0 = x0;
        in_x1 = x1;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_ready && cnt < 200);
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Collects n results, checking latency, data, index and last flag; optional backpressure at bp_f.
    task automatic collect(input longint x0, input longint x1, input int n, input int bp_f, input int bp_cycles);
        for (int f = 0; f < n; f++) begin
            int     cnt = 0;
            int     d;
            longint exp_v;
            d = int'($urandom_range(0, 4));
            mem_delay = d;
            exp_v = model(x0, x1, f);
            do begin
                @(negedge clk);
                cnt++;
                if (cnt == 1) check("mem_start_after_step", longint'(mem_start), 1);
                if (mem_start) check("mem_filter", longint'(mem_filter), f);
            end while (!out_valid && cnt < 40);
            check("latency", cnt, d + 3);
            check("out_data", longint'($signed(out_data)), exp_v);
            check("out_filter", longint'(out_filter), f);
            check("out_last", longint'(out_last), (f == NF - 1) ? 1 : 0);
            got_d[f] = longint'($signed(out_data));
            if (f == bp_f) begin
                out_ready = 1'b0;
                for (int k = 0; k < bp_cycles; k++) begin
                    @(negedge clk);
                    check("bp_valid", longint'(out_valid), 1);
                    check("bp_data", longint'($signed(out_data)), exp_v);
                    check("bp_filter", longint'(out_filter), f);
                    check("bp_no_mem_start", longint'(mem_start), 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] ax, bx, cx, dx;
        int acc0;

        for (int f = 0; f < 32; f++) begin
            wm0[f] = 16'($urandom);
            wm1[f] = 16'($urandom);
            bm[f]  = $urandom;
        end
        wm0[0]  = -16'sd551; wm1[0]  = 16'sd577;  bm[0]  = 32'sd477383;
        wm0[13] = 16'sd978;  wm1[13] = -16'sd942; bm[13] = -32'sd780901;
        wm0[19] = -16'sd647; wm1[19] = 16'sd658;  bm[19] = -32'sd1882176;

        #23;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_mem_start", longint'(mem_start), 0);
        check("rst_mem_filter", longint'(mem_filter), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_filter", longint'(out_filter), 0);
        check("rst_out_last", longint'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", longint'(in_ready), 1);

        // Reference pass with known weights.
        send_pair(16'sd256, 16'sd256);
        collect(256, 256, NF, -1, 0);
        check("f0_const", got_d[0], 1890);
        check("f19_const", got_d[19], EXP_F19);

        // Saturation both directions.
        send_pair(16'sd32767, 16'sd0);
        collect(32767, 0, NF, -1, 0);
        check("sat_pos_f13", got_d[13], 32767);
        send_pair(-16'sd32768, 16'sd32767);
        collect(-32768, 32767, NF, -1, 0);
        check("sat_neg_f13", got_d[13], EXP_SATNEG);

        // Backpressure at filter 4.
        ax = 16'($urandom); bx = 16'($urandom);
        send_pair(ax, bx);
        collect(longint'(ax), longint'(bx), NF, 4, 5);

        // Reset during MAC of filter 7.
        ax = 16'($urandom); bx = 16'($urandom);
        send_pair(ax, bx);
        collect(longint'(ax), longint'(bx), 7, -1, 0);
        mem_delay = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", longint'(in_ready), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_mem_start", longint'(mem_start), 0);
        check("mid_rst_mem_filter", longint'(mem_filter), 0);
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_out_data", longint'(out_data), 0);
        check("mid_rst_out_filter", longint'(out_filter), 0);
        check("mid_rst_out_last", longint'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_out_valid", longint'(out_valid), 0);
            check("post_rst_in_ready", longint'(in_ready), 1);
        end
        ax = 16'($urandom); bx = 16'($urandom);
        send_pair(ax, bx);
        collect(longint'(ax), longint'(bx), NF, -1, 0);

        // Back-to-back: second pair held valid for the whole first pass.
        ax = 16'($urandom); bx = 16'($urandom);
        cx = 16'($urandom); dx = 16'($urandom);
        send_pair(ax, bx);
        acc0 = n_acc;
        in_x0 = cx;
        in_x1 = dx;
        in_valid = 1'b1;
        collect(longint'(ax), longint'(bx), NF, -1, 0);
        check("b2b_no_early_accept", n_acc, acc0);
        @(negedge clk);
        check("b2b_in_ready", longint'(in_ready), 1);
        check("b2b_out_valid_low", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accept_once", n_acc, acc0 + 1);
        collect(longint'(cx), longint'(dx), NF, -1, 0);

        // Random passes with random memory latency.
        for (int r = 0; r < 3; r++) begin
            ax = 16'($urandom); bx = 16'($urandom);
            send_pair(ax, bx);
            collect(longint'(ax), longint'(bx), NF, int'($urandom_range(0, NF - 1)), int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv1_filter_engine.md
Name: conv1_filter_engine

Overview:
- Sequencer and MAC datapath on the read side of the conv1 weights memory.
- Accepts one input sample pair (x0, x1) and walks filter indices 0..NUM_FILTERS-1. For each filter it requests w0/w1/b from the weights memory, computes one conv1 output, and streams results downstream over a valid/ready handshake.
- Sits between the input sample buffer and the conv1 feature-map writer.

Parameters:
- NUM_FILTERS, 20, number of filters iterated per input pair; max 32 because the index is 5 bits.
- FRAC_BITS, 8, arithmetic right shift applied to the accumulator before output saturation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input pair valid.
- in_ready  output  1  engine can accept a pair.
- in_x0  input  16  signed sample, tap 0.
- in_x1  input  16  signed sample, tap 1.
- mem_start  output  1  weight request to the weights memory.
- mem_filter  output  5  filter index requested.
- mem_w0  input  16  signed weight, tap 0.
- mem_w1  input  16  signed weight, tap 1.
- mem_b  input  32  signed bias, in product scale.
- mem_done  input  1  weights valid for mem_filter.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  16  signed saturated result.
- out_filter  output  5  filter index of out_data.
- out_last  output  1  out_data belongs to the last filter.
- busy  output  1  engine is not in IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, filter index=0, all outputs 0 (in_ready=0 while rst_n=0), all datapath registers 0.
- Reset asserted mid-operation aborts the pass immediately; no partial results are emitted after release.
- in_ready=1 only in IDLE.

FSM states: IDLE, FETCH, MAC, OUT.
- IDLE:
  - in_valid & in_ready → latch in_x0/in_x1, filter index=0, go to FETCH.
- FETCH:
  - mem_start=1, mem_filter=index.
  - Wait until mem_done=1, then register mem_w0/mem_w1/mem_b and go to MAC.
  - mem_done is sampled only while mem_start=1.
  - Any mem_done latency is tolerated, including same-cycle done; there is no timeout.
- MAC:
  - acc = x0*w0 + x1*w1 + b, computed at 34 bits signed.
  - Each product is 32-bit signed; sign-extend everything before summing.
  - res = acc >>> FRAC_BITS (arithmetic, floor).
  - Saturate res to [-32768, 32767], register it into out_data, go to OUT.
- OUT:
  - out_valid=1; out_filter=index; out_last=(index==NUM_FILTERS-1).
  - out_data, out_filter, out_last stay stable until out_valid & out_ready.
  - On handshake, if out_last: index=0 and go to IDLE; otherwise index+1 and go to FETCH.
  - out_valid deasserts the cycle after the handshake.
- mem_start=0 outside FETCH; mem_filter holds the current index.
- busy=1 in FETCH, MAC and OUT.

Timing:
- Latency: pair accepted at edge T → mem_start at T+1. With same-cycle mem_done, first out_valid is at T+3.
- Throughput with out_ready held high and same-cycle mem_done: one result per 3 cycles; NUM_FILTERS*3 cycles per pair.
- Back-to-back pairs: in_ready rises in the cycle after the last handshake. No pair is accepted in the same cycle as the final output.
- in_valid asserted while busy is ignored; the upstream producer holds its pair.

Optional Feature:
- Macro: CONV1_FILTER_ENGINE_RELU_EN.
- Defined: ReLU is applied after saturation; any negative result becomes 0 before registering out_data.
- Undefined: signed saturated result is passed unchanged.
- Latency and handshake are identical in both builds.

Test Plan:
- Single pass, NUM_FILTERS=20, memory loaded with the conv1 weight set, x0=256, x1=256, out_ready=1 → 20 results in filter order 0..19, out_last only on index 19.
  - Filter 0 (w0=-551, w1=577, b=477383) → out_data=1890.
  - Filter 19 (w0=-647, w1=658, b=-1882176) → out_data=-7342 without the macro, 0 with CONV1_FILTER_ENGINE_RELU_EN.
- Saturation: x0=32767, x1=0 → filter 13 (w0=978, w1=-942, b=-780901) gives out_data=32767. With x0=-32768, x1=32767, filter 13 gives -32768 without the macro.
- Backpressure: out_ready=0 for 5 cycles at filter 4 → out_valid held, data/index stable, no mem_start issued; release → next mem_start the cycle after the handshake.
- Memory latency: mem_done delayed 0, 1 and 4 cycles after mem_start → results unchanged, mem_filter stable while waiting, latency grows by the delay.
- Reset mid-pass: drop rst_n during MAC of filter 7 → all outputs 0 asynchronously. After release: in_ready=1, no stray out_valid, and a new pair restarts at filter 0.
- Back-to-back pairs: second in_valid held high throughout the first pass → accepted exactly once, in the cycle after the filter-19 handshake, and its results use the new samples.
